// File: rtl/poly_pkg.sv
// rtl/poly_pkg.sv - shared codes and state encoding for the polynomial accelerator firing controller
//
// Purpose: mode codes, status codes, default opcodes, controller state
// encoding and the status-word packing helper.
// Ports: none (package).

package poly_pkg;

  localparam logic [1:0] MODE_FETCH = 2'b00;
  localparam logic [1:0] MODE_EXEC  = 2'b01;

  localparam logic [1:0] ST_OK      = 2'd0;
  localparam logic [1:0] ST_ILLEGAL = 2'd1;
  localparam logic [1:0] ST_TIMEOUT = 2'd2;
  localparam logic [1:0] ST_ENGINE  = 2'd3;

  localparam int OP_STP = 0;
  localparam int OP_EVP = 1;
  localparam int OP_EVB = 2;
  localparam int OP_RST = 3;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_FWAIT,
    S_DISPATCH,
    S_WAIT,
    S_PWR,
    S_FWR,
    S_EWR,
    S_SRST,
    S_FIN
  } state_t;

  // Status word low byte: [7:4] engine index, [1:0] code, rest zero.
  function automatic logic [7:0] make_status(input logic [1:0] code, input logic [3:0] idx);
    return {idx, 2'b00, code};
  endfunction

endpackage

// File: rtl/poly_watchdog.sv
// rtl/poly_watchdog.sv - saturating wait-cycle watchdog
//
// Purpose: counts enabled cycles since the last clear; expired is high
// once the count equals TIMEOUT. TIMEOUT=0 keeps expired low.
// Ports:
//   clk, rst   clock, asynchronous active-low reset
//   clr        synchronous clear (wins over en)
//   en         count enable
//   expired    count has reached TIMEOUT

module poly_watchdog #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  logic [CW-1:0] count;
  logic          at_limit;

  assign at_limit = (count == CW'(TIMEOUT));
  assign expired  = (TIMEOUT != 0) && at_limit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && !at_limit) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/poly_fire_ctrl.sv
// rtl/poly_fire_ctrl.sv - CFDF firing-state controller with result muxing, partial acks and error status
//
// Purpose: runs one firing per start pulse: command fetch, engine dispatch,
// soft reset, or illegal-request report. Engine results are written to a
// single output port under out_full backpressure.
// Ports:
//   clk, rst                       clock, asynchronous active-low reset
//   start, mode, opcode            firing request (sampled in IDLE)
//   fetch_start / fetch_done       fetch engine handshake
//   op_start / op_done             per-engine start and final-result pulses
//   op_partial / op_ack            per-engine partial result and acknowledge
//   op_result, op_status           flattened engine results and codes
//   out_full / out_wr              output FIFO full / write enable
//   out_result, out_status         written result and status word
//   soft_rst_n                     one-cycle active-low soft reset pulse
//   busy, done                     not-idle flag, firing-complete pulse

module poly_fire_ctrl
  import poly_pkg::*;
#(
  parameter int WORD_SIZE  = 16,
  parameter int OP_W       = 8,
  parameter int NUM_OPS    = 3,
  parameter int RST_OPCODE = 3,
  parameter int TIMEOUT    = 1024
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [1:0]                   mode,
  input  logic [OP_W-1:0]              opcode,
  output logic                         fetch_start,
  input  logic                         fetch_done,
  output logic [NUM_OPS-1:0]           op_start,
  input  logic [NUM_OPS-1:0]           op_done,
  input  logic [NUM_OPS-1:0]           op_partial,
  output logic [NUM_OPS-1:0]           op_ack,
  input  logic [NUM_OPS*WORD_SIZE-1:0] op_result,
  input  logic [NUM_OPS*2-1:0]         op_status,
  input  logic                         out_full,
  output logic                         out_wr,
  output logic [WORD_SIZE-1:0]         out_result,
  output logic [WORD_SIZE-1:0]         out_status,
  output logic                         soft_rst_n,
  output logic                         busy,
  output logic                         done
);

  state_t               state;
  logic [3:0]           sel;
  logic                 cur_done;
  logic                 cur_partial;
  logic [WORD_SIZE-1:0] cur_result;
  logic [1:0]           cur_code;
  logic [NUM_OPS-1:0]   sel_hot;
  logic [NUM_OPS-1:0]   op_hot;
  logic                 waiting;
  logic                 expired;

  // Loop-based mux keeps the 4-bit sel from indexing past NUM_OPS.
  always_comb begin
    cur_done    = 1'b0;
    cur_partial = 1'b0;
    cur_result  = '0;
    cur_code    = '0;
    sel_hot     = '0;
    op_hot      = '0;
    for (int i = 0; i < NUM_OPS; i++) begin
      if (sel == 4'(i)) begin
        cur_done    = op_done[i];
        cur_partial = op_partial[i];
        cur_result  = op_result[i*WORD_SIZE +: WORD_SIZE];
        cur_code    = op_status[i*2 +: 2];
        sel_hot[i]  = 1'b1;
      end
      op_hot[i] = (opcode == OP_W'(i));
    end
  end

  // Watchdog is held clear outside the wait states, so every entry into
  // FWAIT/WAIT (including the return from PWR after an ack) starts from 0.
  assign waiting = (state == S_FWAIT) || (state == S_WAIT);

  poly_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clr     (!waiting),
    .en      (waiting),
    .expired (expired)
  );

  // Only the write-side strobes see out_full combinationally.
  assign busy   = (state != S_IDLE);
  assign out_wr = ((state == S_PWR) || (state == S_FWR) || (state == S_EWR)) && !out_full;
  assign op_ack = ((state == S_PWR) && !out_full) ? sel_hot : '0;
  assign done   = (state == S_FIN) || (((state == S_FWR) || (state == S_EWR)) && !out_full);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      sel         <= '0;
      fetch_start <= 1'b0;
      op_start    <= '0;
      soft_rst_n  <= 1'b1;
      out_result  <= '0;
      out_status  <= '0;
    end else begin
      fetch_start <= 1'b0;
      op_start    <= '0;
      soft_rst_n  <= 1'b1;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (mode == MODE_FETCH) begin
              state       <= S_FETCH;
              fetch_start <= 1'b1;
            end else if (mode == MODE_EXEC && opcode < OP_W'(NUM_OPS)) begin
              state    <= S_DISPATCH;
              sel      <= opcode[3:0];
              op_start <= op_hot;
            end else if (mode == MODE_EXEC && opcode == OP_W'(RST_OPCODE)) begin
              state      <= S_SRST;
              soft_rst_n <= 1'b0;
            end else begin
              state      <= S_EWR;
              out_result <= '0;
              out_status <= WORD_SIZE'(make_status(ST_ILLEGAL, opcode[3:0]));
            end
          end
        end
        S_FETCH:    state <= S_FWAIT;
        S_FWAIT: begin
          if (fetch_done) begin
            state <= S_FIN;
          end else if (expired) begin
            state      <= S_EWR;
            soft_rst_n <= 1'b0;
            out_result <= '0;
            out_status <= WORD_SIZE'(make_status(ST_TIMEOUT, 4'hF));
          end
        end
        S_DISPATCH: state <= S_WAIT;
        S_WAIT: begin
          // Final result takes priority over a coincident partial and over timeout.
          if (cur_done) begin
            state      <= S_FWR;
            out_result <= cur_result;
            out_status <= WORD_SIZE'(make_status(cur_code, sel));
          end else if (cur_partial) begin
            state      <= S_PWR;
            out_result <= cur_result;
            out_status <= WORD_SIZE'(make_status(cur_code, sel));
          end else if (expired) begin
            state      <= S_EWR;
            soft_rst_n <= 1'b0;
            out_result <= '0;
            out_status <= WORD_SIZE'(make_status(ST_TIMEOUT, sel));
          end
        end
        S_PWR:        if (!out_full) state <= S_WAIT;
        S_FWR, S_EWR: if (!out_full) state <= S_IDLE;
        S_SRST:       state <= S_FIN;
        S_FIN:        state <= S_IDLE;
        default:      state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_poly_fire_ctrl.sv
// tb/tb_poly_fire_ctrl.sv - directed self-checking bench for poly_fire_ctrl

module tb_poly_fire_ctrl;

  localparam int WS = 16;
  localparam int NO = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [1:0]    mode;
  logic [7:0]    opcode;
  logic          fetch_start;
  logic          fetch_done;
  logic [NO-1:0] op_start;
  logic [NO-1:0] op_done;
  logic [NO-1:0] op_partial;
  logic [NO-1:0] op_ack;
  logic [NO*WS-1:0] op_result;
  logic [NO*2-1:0]  op_status;
  logic          out_full;
  logic          out_wr;
  logic [WS-1:0] out_result;
  logic [WS-1:0] out_status;
  logic          soft_rst_n;
  logic          busy;
  logic          done;

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] pv [3] = '{16'h0011, 16'h0022, 16'h0033};

  poly_fire_ctrl #(
    .WORD_SIZE(WS), .OP_W(8), .NUM_OPS(NO), .RST_OPCODE(3), .TIMEOUT(8)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .opcode(opcode),
    .fetch_start(fetch_start), .fetch_done(fetch_done),
    .op_start(op_start), .op_done(op_done), .op_partial(op_partial), .op_ack(op_ack),
    .op_result(op_result), .op_status(op_status),
    .out_full(out_full), .out_wr(out_wr), .out_result(out_result), .out_status(out_status),
    .soft_rst_n(soft_rst_n), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge and drop single-cycle inputs.
  task automatic tick();
    @(posedge clk);
    #1;
    start      = 1'b0;
    fetch_done = 1'b0;
    op_done    = '0;
    op_partial = '0;
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; mode = 2'b00; opcode = 8'h00;
    fetch_done = 1'b0; op_done = '0; op_partial = '0;
    op_result = '0; op_status = '0; out_full = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_out_wr", out_wr, 0);
    chk("rst_soft_rst_n", soft_rst_n, 1);
    chk("rst_op_start", op_start, 0);
    chk("rst_out_status", out_status, 0);
    @(negedge clk);
    rst = 1'b1;

    // Execute opcode 1, done five cycles after op_start.
    tick(); start = 1'b1; mode = 2'b01; opcode = 8'd1; #1;
    chk("t1_c0_busy", busy, 0);
    tick();
    chk("t1_op_start", op_start, 3'b010);
    chk("t1_busy", busy, 1);
    repeat (4) tick();
    tick(); op_done = 3'b010; op_result[1*WS +: WS] = 16'h1234; #1;
    chk("t1_no_early_done", done, 0);
    tick(); #1;
    chk("t1_out_wr", out_wr, 1);
    chk("t1_done", done, 1);
    chk("t1_result", out_result, 16'h1234);
    chk("t1_status", out_status, 16'h0010);
    tick();
    chk("t1_idle", busy, 0);
    chk("t1_done_clr", done, 0);

    // Opcode 2 with three partials, then final result coincident with a partial.
    tick(); start = 1'b1; mode = 2'b01; opcode = 8'd2;
    tick();
    chk("t2_op_start", op_start, 3'b100);
    for (int i = 0; i < 3; i++) begin
      tick(); op_partial = 3'b100; op_result[2*WS +: WS] = pv[i];
      if (i == 1) op_done = 3'b001;
      tick(); #1;
      chk("t2_p_wr", out_wr, 1);
      chk("t2_p_ack", op_ack, 3'b100);
      chk("t2_p_result", out_result, {16'h0, pv[i]});
      chk("t2_p_nodone", done, 0);
    end
    tick(); op_done = 3'b100; op_partial = 3'b100; op_result[2*WS +: WS] = 16'h0044;
    tick(); #1;
    chk("t2_f_wr", out_wr, 1);
    chk("t2_f_done", done, 1);
    chk("t2_f_ack", op_ack, 0);
    chk("t2_f_result", out_result, 16'h0044);
    chk("t2_f_status", out_status, 16'h0020);
    tick();
    chk("t2_idle", busy, 0);

    // out_full held four cycles at FWR; engine reports error code 3.
    tick(); start = 1'b1; mode = 2'b01; opcode = 8'd0;
    tick();
    tick(); op_done = 3'b001; op_result[0 +: WS] = 16'hBEEF; op_status[1:0] = 2'b11;
    for (int i = 0; i < 4; i++) begin
      tick(); out_full = 1'b1;
      if (i == 1) begin start = 1'b1; opcode = 8'd7; end
      #1;
      chk("t3_full_wr", out_wr, 0);
      chk("t3_full_done", done, 0);
    end
    tick(); out_full = 1'b0; #1;
    chk("t3_wr", out_wr, 1);
    chk("t3_done", done, 1);
    chk("t3_result", out_result, 16'hBEEF);
    chk("t3_status", out_status, 16'h0003);
    tick();
    chk("t3_idle", busy, 0);
    chk("t3_no_extra_wr", out_wr, 0);
    op_status = '0;

    // Engine 2 never completes: timeout after eight WAIT cycles.
    tick(); start = 1'b1; mode = 2'b01; opcode = 8'd2;
    for (int c = 1; c <= 10; c++) begin
      tick();
      chk("t5_wait_srn", soft_rst_n, 1);
      chk("t5_wait_done", done, 0);
    end
    tick(); #1;
    chk("t5_srn", soft_rst_n, 0);
    chk("t5_wr", out_wr, 1);
    chk("t5_done", done, 1);
    chk("t5_status", out_status, 16'h0022);
    chk("t5_result", out_result, 16'h0000);
    tick();
    chk("t5_srn_rel", soft_rst_n, 1);
    chk("t5_idle", busy, 0);

    // Illegal opcode 7.
    tick(); start = 1'b1; mode = 2'b01; opcode = 8'd7;
    tick(); #1;
    chk("t4_wr", out_wr, 1);
    chk("t4_done", done, 1);
    chk("t4_status", out_status, 16'h0071);
    chk("t4_op_start", op_start, 0);
    tick();
    chk("t4_idle", busy, 0);

    // Fetch firing.
    tick(); start = 1'b1; mode = 2'b00;
    tick();
    chk("tf_fetch_start", fetch_start, 1);
    tick(); fetch_done = 1'b1;
    chk("tf_fetch_start_clr", fetch_start, 0);
    chk("tf_busy", busy, 1);
    tick(); #1;
    chk("tf_done", done, 1);
    chk("tf_no_wr", out_wr, 0);
    tick();
    chk("tf_idle", busy, 0);

    // Illegal mode 10, index from opcode[3:0].
    tick(); start = 1'b1; mode = 2'b10; opcode = 8'h25;
    tick(); #1;
    chk("tm_status", out_status, 16'h0051);
    chk("tm_done", done, 1);

    // Soft reset opcode.
    tick(); start = 1'b1; mode = 2'b01; opcode = 8'd3;
    tick(); #1;
    chk("ts_srn", soft_rst_n, 0);
    chk("ts_no_wr", out_wr, 0);
    tick(); #1;
    chk("ts_srn_rel", soft_rst_n, 1);
    chk("ts_done", done, 1);
    chk("ts_no_wr2", out_wr, 0);
    tick();
    chk("ts_done_clr", done, 0);

    // Asynchronous reset during WAIT.
    tick(); start = 1'b1; mode = 2'b01; opcode = 8'd1;
    tick();
    tick();
    chk("tr_pre_busy", busy, 1);
    #2; rst = 1'b0; #1;
    chk("tr_busy", busy, 0);
    chk("tr_srn", soft_rst_n, 1);
    chk("tr_done", done, 0);
    chk("tr_wr", out_wr, 0);
    chk("tr_status", out_status, 0);
    chk("tr_result", out_result, 0);
    @(negedge clk);
    rst = 1'b1;
    tick(); tick();
    chk("tr_stay_idle", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/poly_fire_ctrl.md
# poly_fire_ctrl

Parametrised firing-state controller for the polynomial evaluation accelerator: sequences one CFDF firing per `start` pulse, either fetching a command through the fetch engine or dispatching a decoded opcode to one of `NUM_OPS` instruction engines (STP, EVP, EVB by default). It adds three behaviours the previous controller lacked:
- Muxes engine results onto a single output port with `out_full` backpressure.
- Acknowledges partial (batch) results.
- Reports illegal opcodes/modes and engine timeouts as status words.

## Interface
Parameters:
- `WORD_SIZE`, 16: result/status width; must be ≥ 8.
- `OP_W`, 8: opcode width.
- `NUM_OPS`, 3: number of instruction engines; opcode i (i < `NUM_OPS`) selects engine i; must be ≤ 16.
- `RST_OPCODE`, 3: opcode executed as soft reset; must be ≥ `NUM_OPS`.
- `TIMEOUT`, 1024: max wait cycles for fetch/engine; 0 disables the watchdog.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-low.
- `start`  in  1  firing request from parent FSM; sampled in IDLE only.
- `mode`  in  2  00 fetch command, 01 execute `opcode`, 10/11 illegal.
- `opcode`  in  `OP_W`  decoded instruction; sampled with `start`.
- `fetch_start`  out  1  one-cycle start pulse to the fetch engine.
- `fetch_done`  in  1  fetch complete pulse.
- `op_start`  out  `NUM_OPS`  one-hot, one-cycle engine start.
- `op_done`  in  `NUM_OPS`  engine final-result pulse.
- `op_partial`  in  `NUM_OPS`  engine partial result valid; held until acked.
- `op_ack`  out  `NUM_OPS`  one-hot, one-cycle partial-result acknowledge.
- `op_result`  in  `NUM_OPS*WORD_SIZE`  flattened engine results; engine i at slice [i*WORD_SIZE +: WORD_SIZE].
- `op_status`  in  `NUM_OPS*2`  engine completion codes, same slicing.
- `out_full`  in  1  output FIFO full.
- `out_wr`  out  1  output FIFO write enable.
- `out_result`  out  `WORD_SIZE`  result word.
- `out_status`  out  `WORD_SIZE`  status word: [1:0] code, [7:4] engine index, all other bits 0.
- `soft_rst_n`  out  1  one-cycle active-low pulse to engines, fetch engine and memory controllers.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle firing-complete pulse to parent.

## Operation
- States:
  - IDLE.
  - FETCH (`fetch_start`=1) → FWAIT.
  - DISPATCH (`op_start`[sel]=1) → WAIT.
  - PWR: partial write.
  - FWR: final write.
  - EWR: error write.
  - SRST.
  - FIN: `done`=1.
- Status codes: 0 OK, 1 illegal opcode/mode, 2 timeout, 3 engine-reported error (passed through from `op_status`).
- Transitions out of IDLE on `start`:
  - `mode`=00 → FETCH.
  - `mode`=01 with `opcode` < `NUM_OPS` → DISPATCH; sel latched.
  - `mode`=01 with `opcode`=`RST_OPCODE` → SRST.
  - Any other combination → EWR with code 1; index field = `opcode`[3:0].
- FETCH/FWAIT: FWAIT → FIN on `fetch_done`; no output write.
- WAIT:
  - `op_done`[sel] → latch result/status, go to FWR.
  - Otherwise `op_partial`[sel] → latch, go to PWR.
  - Partial and done in the same cycle: done wins, partial dropped.
  - Done/partial bits of non-selected engines are ignored.
- PWR: hold while `out_full`; otherwise `out_wr`=1 and `op_ack`[sel]=1 in the same cycle, then return to WAIT.
- FWR/EWR: hold while `out_full`; otherwise `out_wr`=1 and `done`=1 in the same cycle, then IDLE.
- SRST: `soft_rst_n`=0 for one cycle → FIN. No output write.
- Watchdog:
  - Counts cycles in FWAIT/WAIT; cleared on entering either state and on each `op_ack`.
  - Count reaching `TIMEOUT`: `soft_rst_n`=0 for one cycle, result 0, code 2, go to EWR.
  - In FWAIT the index field is 0xF.
- `start` while `busy` is ignored.

## Timing
- Reset values: all outputs 0 except `soft_rst_n`=1; state IDLE; latches and watchdog cleared. Reset mid-firing aborts immediately; nothing is written.
- Outputs are registered decodes of state; no combinational input-to-output path except the `out_full` gating of `out_wr`/`op_ack`/`done`.
- Execute latency, with `start` in cycle 0:
  - `op_start` in cycle 1; WAIT from cycle 2.
  - `op_done` in cycle k → `out_wr` and `done` in cycle k+1 when not full.
- Fetch latency: `fetch_start` in cycle 1; `fetch_done` in cycle k → `done` in cycle k+1.
- Illegal opcode: `out_wr` and `done` in cycle 1.
- Soft reset: `soft_rst_n` low in cycle 1; `done` in cycle 2.

## Structure
- Shared package `poly_pkg`: mode codes, status codes, default opcodes (STP=0, EVP=1, EVB=2, RST=3), state encoding.
- Sub-module `poly_watchdog`: counter with clear, enable, and `expired` output; `TIMEOUT`=0 ties `expired` low.

## Test plan
- `mode`=01, `opcode`=1, `op_done`[1] 5 cycles after `op_start` with result 0x1234 → `out_result`=0x1234 and `out_status`=0x0010 in the same cycle as `done`.
- `opcode`=2; three `op_partial`[2] pulses (0x11, 0x22, 0x33) then `op_done` (0x44) → four writes in order, three `op_ack`[2] pulses, one `done`.
- `out_full` held for 4 cycles at FWR → no write until it drops; exactly one `out_wr`, coincident with `done`.
- `opcode`=7 → `out_status`=0x0071 in cycle 1 and `done`; no `op_start`.
- `TIMEOUT`=8 and the engine never completes → `soft_rst_n` low for one cycle, then `out_status`=0x0002 plus index, result 0, `done`.
- `opcode`=3 → `soft_rst_n` low in cycle 1, `done` in cycle 2, no write; async `rst` asserted during WAIT → all outputs return to reset values.
